// File: rtl/proc_pkg.sv
// proc_pkg: shared FSM encoding, width default and STEP legality check for shift_right_unit
package proc_pkg;

    localparam int SR_DATA_W = 32;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_e;

    function automatic bit step_legal(input int step);
        return step == 1 || step == 2 || step == 4 || step == 8;
    endfunction

endpackage

// File: rtl/shift_right_unit_if.sv
// shift_right_unit_if: request/result bundle between the EX stage and the shift unit
interface shift_right_unit_if import proc_pkg::*; #(
    parameter int DATA_W  = SR_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
);
    logic               start;
    logic [DATA_W-1:0]  A;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               rot;
    logic [DATA_W-1:0]  Out;
    logic               busy;
    logic               done;

    modport master (output start, A, shamt, arith, rot, input Out, busy, done);
    modport slave  (input start, A, shamt, arith, rot, output Out, busy, done);
endinterface

// File: rtl/shift_right_unit_step.sv
// shift_step: combinational right shift of d by k (0..STEP) with zero, sign or rotate fill
module shift_step #(
    parameter int DATA_W = 32,
    parameter int STEP   = 1,
    parameter int KW     = $clog2(STEP + 1)
) (
    input  logic [DATA_W-1:0] d,
    input  logic [KW-1:0]     k,
    input  logic              arith,
    input  logic              rot,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] fill;

    // fill source: the operand itself for rotate, else a sign or zero word; rotate wins over arith
    always_comb begin
        fill = rot ? d : {DATA_W{arith & d[DATA_W-1]}};
        q = d;
        for (int i = 1; i <= STEP; i++)
            if (k == KW'(i)) q = (d >> i) | (fill << (DATA_W - i));
    end
endmodule

// File: rtl/shift_right_unit.sv
// shift_right_unit: multi-cycle SRL/SRA (ROTR when ROTATE_EN is defined), STEP bits per clock
module shift_right_unit import proc_pkg::*; #(
    parameter int DATA_W  = SR_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W),
    parameter int STEP    = 1
) (
    input logic              clk,
    input logic              rst,
    shift_right_unit_if.slave io
);
    localparam int KW = $clog2(STEP + 1);
`ifdef ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    if (!step_legal(STEP)) begin : g_bad_step
        $error("shift_right_unit: STEP must be 1, 2, 4 or 8");
    end
    if (SHAMT_W != $clog2(DATA_W)) begin : g_bad_shamt_w
        $error("shift_right_unit: SHAMT_W must equal clog2(DATA_W)");
    end

    sr_state_e          state;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] count_nx;
    logic [KW-1:0]      k;
    logic               arith_q;
    logic               rot_q;
    logic [DATA_W-1:0]  shifted;

    // this cycle's step is min(STEP, count), so the count lands exactly on zero
    always_comb begin
        k        = int'(count) >= STEP ? KW'(STEP) : KW'(count);
        count_nx = count - SHAMT_W'(k);
    end

    shift_step #(.DATA_W(DATA_W), .STEP(STEP)) u_step (
        .d     (io.Out),
        .k     (k),
        .arith (arith_q),
        .rot   (rot_q),
        .q     (shifted)
    );

    // IDLE -> SHIFT -> DONE -> IDLE with registered busy/done; Out doubles as the working register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SR_IDLE;
            io.Out  <= '0;
            io.busy <= 1'b0;
            io.done <= 1'b0;
            count   <= '0;
            arith_q <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            case (state)
                SR_IDLE: if (io.start) begin
                    io.Out  <= io.A;
                    count   <= io.shamt;
                    arith_q <= io.arith;
                    rot_q   <= ROT_EN & io.rot;
                    io.busy <= 1'b1;
                    io.done <= io.shamt == '0;
                    state   <= io.shamt == '0 ? SR_DONE : SR_SHIFT;
                end
                SR_SHIFT: begin
                    io.Out  <= shifted;
                    count   <= count_nx;
                    io.done <= count_nx == '0;
                    state   <= count_nx == '0 ? SR_DONE : SR_SHIFT;
                end
                SR_DONE: begin
                    io.done <= 1'b0;
                    io.busy <= 1'b0;
                    state   <= SR_IDLE;
                end
                default: state <= SR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: scoreboard bench driving STEP=1 and STEP=4 units with shared stimulus
module tb_shift_right_unit;
`ifdef ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic [31:0] v;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [4:0]  sh = '0;
    logic        arith = 1'b0;
    logic        rot = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    exp_t        q1[$];
    exp_t        q4[$];
    exp_t        e1;
    exp_t        e4;
    logic        pd1 = 1'b0;
    logic        pd4 = 1'b0;
    logic [31:0] last1 = '0;
    logic [31:0] last4 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_right_unit_if #(.DATA_W(32), .SHAMT_W(5)) io1 ();
    shift_right_unit_if #(.DATA_W(32), .SHAMT_W(5)) io4 ();

    assign io1.start = start;
    assign io1.A     = a;
    assign io1.shamt = sh;
    assign io1.arith = arith;
    assign io1.rot   = rot;
    assign io4.start = start;
    assign io4.A     = a;
    assign io4.shamt = sh;
    assign io4.arith = arith;
    assign io4.rot   = rot;

    shift_right_unit #(.DATA_W(32), .SHAMT_W(5), .STEP(1)) dut1 (.clk(clk), .rst(rst), .io(io1.slave));
    shift_right_unit #(.DATA_W(32), .SHAMT_W(5), .STEP(4)) dut4 (.clk(clk), .rst(rst), .io(io4.slave));

    function automatic logic [31:0] ref_model(input logic [31:0] av, input int s, input bit ar, input bit ro);
        if (ro && ROT) return s == 0 ? av : (av >> s) | (av << (32 - s));
        if (ar) return $signed(av) >>> s;
        return av >> s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // STEP=1 monitor: pop on done, check value, latency, busy shape and idle hold
    always @(negedge clk) begin
        if (rst) begin
            pd1   <= 1'b0;
            last1 <= '0;
        end else begin
            if (io1.done) begin
                if (q1.size() == 0) check("s1_spurious_done", 32'(io1.done), 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check("s1_out", io1.Out, e1.v);
                    check("s1_latency", cyc, e1.at);
                    check("s1_busy_in_done", 32'(io1.busy), 32'd1);
                    last1 <= e1.v;
                end
            end
            if (pd1) check("s1_busy_after_done", 32'(io1.busy), 32'd0);
            if (!io1.busy) check("s1_idle_hold", io1.Out, last1);
            pd1 <= io1.done;
        end
    end

    // STEP=4 monitor
    always @(negedge clk) begin
        if (rst) begin
            pd4   <= 1'b0;
            last4 <= '0;
        end else begin
            if (io4.done) begin
                if (q4.size() == 0) check("s4_spurious_done", 32'(io4.done), 32'd0);
                else begin
                    e4 = q4.pop_front();
                    check("s4_out", io4.Out, e4.v);
                    check("s4_latency", cyc, e4.at);
                    check("s4_busy_in_done", 32'(io4.busy), 32'd1);
                    last4 <= e4.v;
                end
            end
            if (pd4) check("s4_busy_after_done", 32'(io4.busy), 32'd0);
            if (!io4.busy) check("s4_idle_hold", io4.Out, last4);
            pd4 <= io4.done;
        end
    end

    task automatic issue(input logic [31:0] av, input int sv, input bit ar, input bit ro);
        int n = 0;
        int acc;
        start = 1'b0;
        @(negedge clk);
        while ((io1.busy || io4.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        a = av; sh = 5'(sv); arith = ar; rot = ro; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        q1.push_back('{ref_model(av, sv, ar, ro), acc + sv});
        q4.push_back('{ref_model(av, sv, ar, ro), acc + (sv + 3) / 4});
        start = 1'b0;
        a = $urandom; sh = 5'($urandom); arith = 1'($urandom); rot = 1'($urandom);
    endtask

    // scramble inputs after accept; start pulses only when both units are busy and must ignore it
    task automatic junk(input int n);
        repeat (n) begin
            @(negedge clk);
            a = $urandom; sh = 5'($urandom); arith = 1'($urandom); rot = 1'($urandom);
            start = (io1.busy && io4.busy) ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_out_s1", io1.Out, 32'h0);
        check("rst_busy_s1", 32'(io1.busy), 32'd0);
        check("rst_done_s1", 32'(io1.done), 32'd0);
        check("rst_out_s4", io4.Out, 32'h0);
        check("rst_busy_s4", 32'(io4.busy), 32'd0);
        check("rst_done_s4", 32'(io4.done), 32'd0);
        rst = 1'b0;

        issue(32'h8000_0000, 4, 1'b0, 1'b0);
        junk(3);
        issue(32'h8000_0000, 4, 1'b1, 1'b0);
        issue(32'h1234_5678, 0, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 31, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a = 32'h0; sh = 5'd3; start = io1.busy && io4.busy;
        @(negedge clk);
        start = 1'b0;
        issue(32'h0000_000F, 4, 1'b0, 1'b1);
        issue(32'h0000_000F, 4, 1'b1, 1'b1);
        issue(32'h8765_4321, 31, 1'b1, 1'b0);

        issue(32'hF000_0000, 20, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy_s1", 32'(io1.busy), 32'd0);
        check("midrst_done_s1", 32'(io1.done), 32'd0);
        check("midrst_out_s1", io1.Out, 32'h0);
        check("midrst_busy_s4", 32'(io4.busy), 32'd0);
        check("midrst_done_s4", 32'(io4.done), 32'd0);
        check("midrst_out_s4", io4.Out, 32'h0);
        q1.delete();
        q4.delete();
        rst = 1'b0;
        issue(32'hA5A5_5A5A, 7, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            junk(int'($urandom_range(0, 12)));
        end

        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", q1.size(), q4.size());
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
